// File: rtl/memory_bus_responder.sv
// Memory bus responder: word RAM plus MMIO page (GPIO, 64-bit cycle counter).
// Optional sticky unmapped-access flag enabled with `define MEM_BUS_FAULT_EN.
module memory_bus_responder #(
  parameter int          MEMORY_WORDS = 1024,
  parameter logic [31:0] MMIO_BASE    = 32'h0000_1000,
  parameter logic [31:0] GPIO_RESET   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memory_read,
  input  logic        memory_write,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        read_valid,
  output logic [31:0] gpio_out,
  output logic        bus_error
);

  localparam int AW = (MEMORY_WORDS > 1) ? $clog2(MEMORY_WORDS) : 1;

  localparam logic [1:0] OFF_GPIO = 2'd0;
  localparam logic [1:0] OFF_LO   = 2'd1;
  localparam logic [1:0] OFF_HI   = 2'd2;
  localparam logic [1:0] OFF_CTRL = 2'd3;

  logic [31:0] mem [MEMORY_WORDS];
  logic [63:0] counter;
  logic [31:0] hi_snapshot;

  logic          ram_hit;
  logic          mmio_hit;
  logic [31:0]   mmio_off;
  logic [AW-1:0] ram_idx;
  logic [31:0]   rd_next;
  logic          cnt_clear;
  logic          lo_read;

  // Address decode: RAM at the bottom, 4-word MMIO page, nothing aliases.
  always_comb begin
    mmio_off = address - MMIO_BASE;
    ram_hit  = address < 32'(MEMORY_WORDS);
    mmio_hit = (address >= MMIO_BASE) && (mmio_off < 32'd4);
    ram_idx  = address[AW-1:0];
  end

  // Read mux and MMIO side-effect strobes for the current cycle.
  always_comb begin
    rd_next   = 32'h0;
    cnt_clear = 1'b0;
    lo_read   = 1'b0;
    if (ram_hit) begin
      rd_next = mem[ram_idx];
    end else if (mmio_hit) begin
      unique case (mmio_off[1:0])
        OFF_GPIO: rd_next = gpio_out;
        OFF_LO: begin
          rd_next = counter[31:0];
          lo_read = memory_read;
        end
        OFF_HI:   rd_next = hi_snapshot;
        OFF_CTRL: rd_next = 32'h0;
      endcase
      cnt_clear = memory_write && (mmio_off[1:0] == OFF_CTRL) && write_data[0];
    end
  end

  // RAM write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (reset && memory_write && ram_hit) begin
      mem[ram_idx] <= write_data;
    end
  end

  // Registered read response; read-before-write falls out of NBA ordering.
  always_ff @(posedge clk) begin
    if (!reset) begin
      read_data  <= 32'h0;
      read_valid <= 1'b0;
    end else begin
      read_valid <= memory_read;
      if (memory_read) begin
        read_data <= rd_next;
      end
    end
  end

  // GPIO register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      gpio_out <= GPIO_RESET;
    end else if (memory_write && mmio_hit && mmio_off[1:0] == OFF_GPIO) begin
      gpio_out <= write_data;
    end
  end

  // Free-running counter; clear wins over increment.
  always_ff @(posedge clk) begin
    if (!reset) begin
      counter <= 64'h0;
    end else if (cnt_clear) begin
      counter <= 64'h0;
    end else begin
      counter <= counter + 64'd1;
    end
  end

  // High half captured with the low-half read so hi/lo pairs are coherent.
  always_ff @(posedge clk) begin
    if (!reset) begin
      hi_snapshot <= 32'h0;
    end else if (lo_read) begin
      hi_snapshot <= counter[63:32];
    end
  end

`ifdef MEM_BUS_FAULT_EN
  // Sticky flag for any access outside RAM and the MMIO page.
  always_ff @(posedge clk) begin
    if (!reset) begin
      bus_error <= 1'b0;
    end else if ((memory_read || memory_write) && !ram_hit && !mmio_hit) begin
      bus_error <= 1'b1;
    end
  end
`else
  assign bus_error = 1'b0;
`endif

endmodule

// File: tb/tb_memory_bus_responder.sv
// Directed bench for memory_bus_responder.
// Hand-computed expectations for RAM, GPIO, counter coherence, unmapped, reset.
module tb_memory_bus_responder;

  localparam logic [31:0] MB = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        memory_read = 1'b0;
  logic        memory_write = 1'b0;
  logic [31:0] address = 32'h0;
  logic [31:0] write_data = 32'h0;
  logic [31:0] read_data;
  logic        read_valid;
  logic [31:0] gpio_out;
  logic        bus_error;

  int checks = 0;
  int errors = 0;

`ifdef MEM_BUS_FAULT_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  memory_bus_responder #(
    .MEMORY_WORDS(1024),
    .MMIO_BASE(MB),
    .GPIO_RESET(32'h0)
  ) dut (
    .clk(clk),
    .reset(reset),
    .memory_read(memory_read),
    .memory_write(memory_write),
    .address(address),
    .write_data(write_data),
    .read_data(read_data),
    .read_valid(read_valid),
    .gpio_out(gpio_out),
    .bus_error(bus_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One bus cycle: drive, take the edge, settle for sampling.
  task automatic cyc(input logic rd, input logic wr,
                     input logic [31:0] a, input logic [31:0] d);
    memory_read  = rd;
    memory_write = wr;
    address      = a;
    write_data   = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    check("rst_rdata", read_data, 32'h0);
    check("rst_valid", 32'(read_valid), 32'h0);
    check("rst_gpio", gpio_out, 32'h0);
    check("rst_err", 32'(bus_error), 32'h0);
    reset = 1'b1;

    cyc(0, 1, 5, 32'h1234_5678);
    cyc(1, 0, 5, 0);
    check("ram5_data", read_data, 32'h1234_5678);
    check("ram5_valid", 32'(read_valid), 32'h1);
    cyc(0, 0, 0, 0);
    check("idle_valid", 32'(read_valid), 32'h0);
    check("idle_hold", read_data, 32'h1234_5678);

    cyc(0, 1, 7, 32'hA);
    cyc(1, 1, 7, 32'hB);
    check("rbw_old", read_data, 32'hA);
    check("rbw_valid", 32'(read_valid), 32'h1);
    cyc(1, 0, 7, 0);
    check("rbw_new", read_data, 32'hB);

    cyc(0, 1, MB, 32'hFF);
    check("gpio_out", gpio_out, 32'hFF);
    cyc(1, 0, MB, 0);
    check("gpio_rd", read_data, 32'hFF);

    cyc(0, 1, MB + 3, 32'h1);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(1, 0, MB + 1, 0);
    check("cnt_lo", read_data, 32'h2);
    cyc(1, 0, MB + 2, 0);
    check("cnt_hi", read_data, 32'h0);
    cyc(1, 0, MB + 3, 0);
    check("ctrl_rd", read_data, 32'h0);

    force dut.counter = 64'h0000_0000_FFFF_FFFF;
    release dut.counter;
    cyc(1, 0, MB + 1, 0);
    check("carry_lo", read_data, 32'hFFFF_FFFF);
    cyc(1, 0, MB + 2, 0);
    check("carry_hi", read_data, 32'h0);
    cyc(1, 0, MB + 1, 0);
    check("carry_lo2", read_data, 32'h1);
    cyc(1, 0, MB + 2, 0);
    check("carry_hi2", read_data, 32'h1);

    cyc(0, 1, MB + 8, 32'hDEAD);
    check("unm_wr_hold", read_data, 32'h1);
    check("unm_wr_valid", 32'(read_valid), 32'h0);
    check("unm_err", 32'(bus_error), 32'(ERR_EXP));
    cyc(0, 1, 1024 + 5, 32'hBAD);
    cyc(1, 0, 5, 0);
    check("no_alias", read_data, 32'h1234_5678);
    cyc(1, 0, 32'd2000, 0);
    check("unm_rd", read_data, 32'h0);
    check("unm_rd_valid", 32'(read_valid), 32'h1);
    check("gpio_kept", gpio_out, 32'hFF);

    reset = 1'b0;
    cyc(1, 0, 5, 0);
    check("mid_rst_valid", 32'(read_valid), 32'h0);
    check("mid_rst_data", read_data, 32'h0);
    check("mid_rst_gpio", gpio_out, 32'h0);
    check("mid_rst_err", 32'(bus_error), 32'h0);
    reset = 1'b1;
    cyc(1, 0, 5, 0);
    check("ram_kept", read_data, 32'h1234_5678);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
